scc_mixer: RTL and testbench
============================

Name: scc_mixer

Overview:
- Time-multiplexed channel sequencer and mixer for the SCC wave-table core.
- Drives the 3-bit channel index that the six-way channel selector decodes.
- Consumes the selected channel's wave sample and volume, scales them, and accumulates six channels into one mixed sample per frame.
- Sits directly downstream of the selector and feeds the audio output/DAC stage.

Parameters:
- out_bits, 15, width of mix_out; legal range 8..15; mix_out = acc[14 -: out_bits], i.e. arithmetic truncation of the 15-bit sum.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  slot-advance strobe; may be held high continuously or pulsed with arbitrary gaps.
- active  output  3  current slot index, 0..7; drives the selector; slots 6 and 7 select zero.
- sample_in  input  8  selected channel wave sample, signed two's complement, combinationally valid for the current active.
- volume_in  input  4  selected channel volume, unsigned 0..15, combinationally valid for the current active.
- key_on  input  6  per-channel enable mask; bit k gates channel k.
- mix_out  output  out_bits  signed mixed sample of the last completed frame.
- mix_valid  output  1  one-clock pulse when mix_out updates.

Behaviour:
- Reset state, asynchronous and immediate: active=0, prod_q=0, acc=0, mix_out=0, mix_valid=0.
- All state changes only on clock edges with enable=1, except mix_valid, which is cleared on every edge where enable=0.
- A frame is 8 slots, active=0..7. On enable, active increments modulo 8 (7 wraps to 0).
- Stage 1, product, on enable:
  - prod_q <= (active<=5 && key_on[active]) ? signed(sample_in) * unsigned(volume_in) : 0.
  - prod_q is 12-bit signed; its range is -1920..+1905.
  - Slots 6 and 7 always load 0, independent of the inputs.
- Stage 2, accumulate, on the same enable:
  - If active==7: mix_out <= acc[14 -: out_bits], mix_valid <= 1, acc <= 0.
  - Otherwise: acc <= acc + sign_extend(prod_q).
  - acc is 15-bit signed; its range is -11520..+11430, so no overflow and no saturation is possible.
- Pipeline alignment:
  - The product for slot k is captured at the enable where active==k and is accumulated at the next enable.
  - The slot-5 product is added at the active==6 enable.
  - The total is published at the active==7 enable.
  - At the active==0 enable, the accumulator adds prod_q from slot 7, which is always 0.
- Latency: mix_out and mix_valid change on the clock edge of the enable at which active==7. mix_valid is high for exactly one clock after that edge.
- Gapped enables:
  - active, prod_q and acc hold between strobes.
  - The upstream selector output must be stable while active is stable; the block samples it only on enable.
- key_on is sampled per slot at stage 1. A mask change mid-frame affects only the slots sampled after the change.
- volume_in=0 or key_on bit=0 gives a zero contribution. Treat sample_in=-128 as -128, never as +128.
- Back-to-back frames with enable held high: a new frame starts immediately; mix_valid pulses every 8 clocks.
- Reset mid-frame: the partial frame is discarded with no mix_valid. The first mix_valid after reset comes at the 8th enable, when active==7, and covers only post-reset slots 0..5.

Test Plan:
1. Assert reset, then release and hold enable=0 → active=0, mix_out=0, mix_valid=0 indefinitely. Then apply 7 enables → no mix_valid; the 8th enable → mix_valid=1 for 1 clock.
2. out_bits=15, enable held high, all slots sample=+10, vol=15, key_on=6'h3F → mix_out=900 (0x0384); mix_valid every 8 clocks.
3. Extremes, all channels on, vol=15:
   - sample=-128 → mix_out=-11520 (15-bit 0x5300).
   - sample=+127 → mix_out=+11430 (0x2CA6).
4. key_on=6'b000001, ch0 sample=5 vol=3, ch1..5 sample=100 vol=15 → mix_out=15. Then key_on=6'h00 → mix_out=0.
5. Enables spaced 1..5 clocks at random, stimulus of test 2 → identical mix_out=900; active is stable between strobes; exactly one mix_valid per 8 enables.
6. Reset pulse while active==3 mid-frame → active, acc and mix_out all 0 immediately. No mix_valid until 8 more enables; that frame's value reflects only post-reset inputs.
7. out_bits=11 with the stimulus of test 2 → mix_out=900>>>4=56. With the stimulus of test 3 (sample=-128) → -720.

Source files
------------

// File: rtl/scc_mixer.sv
// SCC channel sequencer and mixer: walks slots 0..7, scales each enabled channel's
// sample by its volume, sums six channels and publishes one mixed sample per frame.
module scc_mixer #(
  parameter int out_bits = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic [2:0]                 active,
  input  logic [7:0]                 sample_in,
  input  logic [3:0]                 volume_in,
  input  logic [5:0]                 key_on,
  output logic signed [out_bits-1:0] mix_out,
  output logic                       mix_valid
);

  logic [2:0]                 active_q, active_d;
  logic signed [11:0]         prod_q, prod_d;
  logic signed [14:0]         acc_q, acc_d;
  logic signed [out_bits-1:0] mix_q, mix_d;
  logic                       valid_q, valid_d;
  logic [7:0]                 key_ext_s;
  logic                       key_sel_s;
  logic signed [12:0]         prod_full_s;

  // Signed sample times unsigned volume; the volume gets a zero sign bit so -128 stays negative.
  function automatic logic signed [12:0] scale(input logic [7:0] s, input logic [3:0] v);
    logic signed [12:0] s_ext;
    logic signed [12:0] v_ext;
    s_ext = $signed({{5{s[7]}}, s});
    v_ext = $signed({9'b0_0000_0000, v});
    return s_ext * v_ext;
  endfunction

  // Slots 6 and 7 map onto the zero-padded mask bits, so they always contribute nothing.
  always_comb begin
    key_ext_s   = {2'b00, key_on};
    key_sel_s   = key_ext_s[active_q];
    prod_full_s = scale(sample_in, volume_in);
  end

  // Next-state: product stage and accumulate stage advance together on each strobe.
  always_comb begin
    active_d = active_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    mix_d    = mix_q;
    valid_d  = 1'b0;
    if (enable) begin
      active_d = active_q + 3'd1;
      prod_d   = key_sel_s ? prod_full_s[11:0] : 12'sd0;
      if (active_q == 3'd7) begin
        mix_d   = acc_q[14 -: out_bits];
        valid_d = 1'b1;
        acc_d   = 15'sd0;
      end else begin
        acc_d = acc_q + $signed({{3{prod_q[11]}}, prod_q});
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 3'd0;
      prod_q   <= 12'sd0;
      acc_q    <= 15'sd0;
      mix_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      mix_q    <= mix_d;
      valid_q  <= valid_d;
    end
  end

  assign active    = active_q;
  assign mix_out   = mix_q;
  assign mix_valid = valid_q;

endmodule

// File: tb/tb_scc_mixer.sv
// Directed bench for scc_mixer: a 15-bit and an 11-bit instance share one modelled
// channel selector driven from the active slot index.
module tb_scc_mixer;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [7:0]         sample_in;
  logic [3:0]         volume_in;
  logic [5:0]         key_on;
  logic [2:0]         active15;
  logic [2:0]         active11;
  logic signed [14:0] mix15;
  logic signed [10:0] mix11;
  logic               valid15;
  logic               valid11;

  logic [7:0] samp_tab [0:7];
  logic [3:0] vol_tab  [0:7];

  int checks;
  int errors;

  scc_mixer #(.out_bits(15)) dut15 (
    .clk(clk), .reset(reset), .enable(enable), .active(active15),
    .sample_in(sample_in), .volume_in(volume_in), .key_on(key_on),
    .mix_out(mix15), .mix_valid(valid15)
  );

  scc_mixer #(.out_bits(11)) dut11 (
    .clk(clk), .reset(reset), .enable(enable), .active(active11),
    .sample_in(sample_in), .volume_in(volume_in), .key_on(key_on),
    .mix_out(mix11), .mix_valid(valid11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector model: slots 6/7 carry non-zero garbage the mixer must ignore.
  always_comb begin
    sample_in = samp_tab[active15];
    volume_in = vol_tab[active15];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] s, input logic [3:0] v);
    for (int k = 0; k < 6; k++) begin
      samp_tab[k] = s;
      vol_tab[k]  = v;
    end
    samp_tab[6] = 8'h55;
    vol_tab[6]  = 4'hF;
    samp_tab[7] = 8'h7F;
    vol_tab[7]  = 4'hF;
  endtask

  // Eight enables from slot 0; enable stays high so frames can run back to back.
  task automatic run_frame(input string tag, input logic signed [31:0] exp15, input logic signed [31:0] exp11);
    chk({tag, "_start_active"}, active15, 0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 7) chk({tag, "_no_valid"}, valid15, 0);
    end
    chk({tag, "_valid15"}, valid15, 1);
    chk({tag, "_valid11"}, valid11, 1);
    chk({tag, "_mix15"}, mix15, exp15);
    chk({tag, "_mix11"}, mix11, exp11);
    chk({tag, "_wrap"}, active11, 0);
  endtask

  initial begin
    int gaps [0:7];
    checks = 0;
    errors = 0;
    gaps = '{1, 3, 5, 2, 4, 1, 5, 3};
    enable = 1'b0;
    key_on = 6'h00;
    set_all(8'd0, 4'd0);
    reset = 1'b1;
    #2;
    chk("rst_active", active15, 0);
    chk("rst_mix15", mix15, 0);
    chk("rst_mix11", mix11, 0);
    chk("rst_valid", valid15, 0);
    tick();
    #2 reset = 1'b0;

    // Idle with enable low: nothing moves.
    repeat (5) tick();
    chk("idle_active", active15, 0);
    chk("idle_valid", valid15, 0);
    chk("idle_mix", mix15, 0);

    // +10 * 15 * 6 = 900, then extremes, then mask cases, all back to back.
    key_on = 6'h3F;
    set_all(8'd10, 4'd15);
    run_frame("basic", 900, 56);
    set_all(8'h80, 4'd15);
    run_frame("neg_ext", -11520, -720);
    set_all(8'd127, 4'd15);
    run_frame("pos_ext", 11430, 714);
    set_all(8'd100, 4'd15);
    samp_tab[0] = 8'd5;
    vol_tab[0]  = 4'd3;
    key_on = 6'b000001;
    run_frame("key_ch0", 15, 0);
    key_on = 6'h00;
    run_frame("key_off", 0, 0);
    enable = 1'b0;
    tick();
    chk("pulse_end", valid15, 0);
    chk("hold_active", active15, 0);

    // Gapped strobes: active holds between strobes, one pulse per 8 strobes.
    key_on = 6'h3F;
    set_all(8'd10, 4'd15);
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1;
      tick();
      enable = 1'b0;
      if (i < 7) chk("gap_no_valid", valid15, 0);
      else begin
        chk("gap_valid", valid15, 1);
        chk("gap_mix15", mix15, 900);
        chk("gap_mix11", mix11, 56);
      end
      chk("gap_active", active15, (i + 1) % 8);
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        chk("gap_hold", active15, (i + 1) % 8);
        chk("gap_idle_valid", valid15, 0);
      end
    end

    // Reset mid-frame at slot 3 with a different stimulus loaded beforehand.
    set_all(8'd127, 4'd15);
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    chk("pre_rst_active", active15, 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_active", active15, 0);
    chk("mid_rst_mix15", mix15, 0);
    chk("mid_rst_mix11", mix11, 0);
    chk("mid_rst_valid", valid15, 0);
    tick();
    #2 reset = 1'b0;
    set_all(8'd10, 4'd15);
    run_frame("post_rst", 900, 56);
    enable = 1'b0;
    tick();
    chk("final_valid", valid15, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
